mix_accum: RTL

MIX_ACCUM -- requirements
Module: mix_accum

---
 rtl/mix_accum.sv | 107 ++++++++++
 1 files changed

// File: rtl/mix_accum.sv
// Frame accumulator for the mix stage: sums and tracks the maximum of COUNT
// unsigned samples per frame, then holds the result until downstream takes it.
module mix_accum #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH+3:0] sum_out,
    output logic [WIDTH-1:0] max_out,
    output logic [4:0]       cnt_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned SUM_W = WIDTH + 4;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   max_q, max_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // State and result registers; reset discards any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath; abort is applied last so it overrides everything.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        max_d   = max_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    sum_d   = '0;
                    max_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    sum_d = sum_q + SUM_W'(in_data);
                    if (in_data > max_q) begin
                        max_d = in_data;
                    end
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            sum_d   = '0;
            max_d   = '0;
            cnt_d   = '0;
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign sum_out   = sum_q;
    assign max_out   = max_q;
    assign cnt_out   = cnt_q;

endmodule
